// File: rtl/decode_uop_seq.sv
// Expands one upstream instruction bundle into a run of micro-op beats and injects a
// fixed interrupt sequence on request. `DECODE_UOP_SEQ_SKID_EN selects a two-entry skid output buffer.
module decode_uop_seq #(
  parameter int IADDRW    = 32,
  parameter int UOPW      = 64,
  parameter int SEQW      = 3,
  parameter int MAXLEN    = 4,
  parameter int INT_ENTRY = 6,
  parameter int INT_LEN   = 3,
  localparam int CW       = $clog2(MAXLEN)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              handle_int_i,
  output logic              handle_int_done_o,
  input  logic              write_eip_i,
  input  logic [31:0]       eip_i,
  output logic [31:0]       eip_reg_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SEQW-1:0]   in_entry_i,
  input  logic [CW:0]       in_len_i,
  input  logic [UOPW-1:0]   in_payload_i,
  input  logic [IADDRW-1:0] in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SEQW-1:0]   out_entry_o,
  output logic [CW-1:0]     out_step_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic              out_int_o,
  output logic [UOPW-1:0]   out_payload_o,
  output logic [IADDRW-1:0] out_pc_o
);

  localparam int INT_LEN_E = (INT_LEN < 1) ? 1 : ((INT_LEN > MAXLEN) ? MAXLEN : INT_LEN);
  localparam logic [CW:0]     MAXLEN_V    = (CW+1)'(MAXLEN);
  localparam logic [CW:0]     INT_LEN_V   = (CW+1)'(INT_LEN_E);
  localparam logic [SEQW-1:0] INT_ENTRY_V = SEQW'(INT_ENTRY);

  typedef enum logic [1:0] {S_IDLE, S_SEQ, S_INT} state_t;

  typedef struct packed {
    logic [SEQW-1:0]   entry;
    logic [CW-1:0]     step;
    logic              first;
    logic              last;
    logic              intr;
    logic [UOPW-1:0]   payload;
    logic [IADDRW-1:0] pc;
  } beat_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     step_q, step_d;
  logic [CW:0]       len_q, len_d;
  logic [SEQW-1:0]   entry_q, entry_d;
  logic [UOPW-1:0]   payload_q, payload_d;
  logic [IADDRW-1:0] pc_q, pc_d;
  logic              int_q, int_d;
  logic [31:0]       eip_reg_q;

  logic  load_ok;
  logic  push;
  beat_t beat;
  logic  out_valid;
  beat_t out_beat;

  function automatic logic [CW:0] eff_len(input logic [CW:0] l);
    if (l == '0)           return (CW+1)'(1);
    else if (l > MAXLEN_V) return MAXLEN_V;
    else                   return l;
  endfunction

  logic [CW:0] in_len_eff;
  assign in_len_eff = eff_len(in_len_i);

  assign in_ready_o = !reset_i && (state_q == S_IDLE) && load_ok && !handle_int_i && !flush_i;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    len_d     = len_q;
    entry_d   = entry_q;
    payload_d = payload_q;
    pc_d      = pc_q;
    int_d     = int_q;
    push      = 1'b0;
    beat      = '0;
    if (flush_i) begin
      state_d = S_IDLE;
      step_d  = '0;
    end else if (load_ok) begin
      case (state_q)
        S_IDLE: begin
          if (handle_int_i) begin
            push         = 1'b1;
            beat.entry   = INT_ENTRY_V;
            beat.first   = 1'b1;
            beat.last    = (INT_LEN_E == 1);
            beat.intr    = 1'b1;
            beat.pc      = IADDRW'(eip_reg_q);
            entry_d      = INT_ENTRY_V;
            len_d        = INT_LEN_V;
            payload_d    = '0;
            pc_d         = IADDRW'(eip_reg_q);
            int_d        = 1'b1;
            if (INT_LEN_E > 1) begin
              state_d = S_INT;
              step_d  = CW'(1);
            end
          end else if (in_valid_i) begin
            push         = 1'b1;
            beat.entry   = in_entry_i;
            beat.first   = 1'b1;
            beat.last    = (in_len_eff == (CW+1)'(1));
            beat.payload = in_payload_i;
            beat.pc      = in_pc_i;
            entry_d      = in_entry_i;
            len_d        = in_len_eff;
            payload_d    = in_payload_i;
            pc_d         = in_pc_i;
            int_d        = 1'b0;
            if (in_len_eff > (CW+1)'(1)) begin
              state_d = S_SEQ;
              step_d  = CW'(1);
            end
          end
        end
        S_SEQ, S_INT: begin
          push         = 1'b1;
          beat.entry   = entry_q;
          beat.step    = step_q;
          beat.first   = (step_q == '0);
          beat.last    = ({1'b0, step_q} == len_q - (CW+1)'(1));
          beat.intr    = int_q;
          beat.payload = payload_q;
          beat.pc      = pc_q;
          // Leave on the final beat so the step counter never passes len-1.
          if (beat.last) begin
            state_d = S_IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      len_q     <= '0;
      entry_q   <= '0;
      payload_q <= '0;
      pc_q      <= '0;
      int_q     <= 1'b0;
      eip_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      len_q     <= len_d;
      entry_q   <= entry_d;
      payload_q <= payload_d;
      pc_q      <= pc_d;
      int_q     <= int_d;
      if (write_eip_i) eip_reg_q <= eip_i;
    end
  end

`ifdef DECODE_UOP_SEQ_SKID_EN
  // Space is judged from the registered count only, so in_ready never sees out_ready.
  beat_t       slot0_q, slot1_q;
  logic [1:0]  cnt_q;
  logic        pop;

  assign load_ok   = (cnt_q != 2'd2);
  assign pop       = (cnt_q != 2'd0) && out_ready_i;
  assign out_valid = (cnt_q != 2'd0);
  assign out_beat  = slot0_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b01: begin
          slot0_q <= slot1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) slot0_q <= beat;
          else               slot1_q <= beat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_q <= beat;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= beat;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic  out_valid_q;
  beat_t out_beat_q;

  assign load_ok   = !out_valid_q || out_ready_i;
  assign out_valid = out_valid_q;
  assign out_beat  = out_beat_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (push) begin
      out_valid_q <= 1'b1;
      out_beat_q  <= beat;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid_o       = out_valid;
  assign out_entry_o       = out_beat.entry;
  assign out_step_o        = out_beat.step;
  assign out_first_o       = out_beat.first;
  assign out_last_o        = out_beat.last;
  assign out_int_o         = out_beat.intr;
  assign out_payload_o     = out_beat.payload;
  assign out_pc_o          = out_beat.pc;
  assign eip_reg_o         = eip_reg_q;
  assign handle_int_done_o = out_valid && out_ready_i && out_beat.last && out_beat.intr;

endmodule

// File: tb/tb_decode_uop_seq.sv
// Randomized and directed bench for decode_uop_seq; expected beat stream is built from
// accepted bundles and requested interrupts, expanded by length rules into a queue.
module tb_decode_uop_seq;
  localparam int IADDRW = 32, UOPW = 64, SEQW = 3, MAXLEN = 4, CW = 2;
  localparam int INT_ENTRY = 6, INT_LEN = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0, handle_int = 1'b0, write_eip = 1'b0;
  logic [31:0]       eip = '0;
  logic              handle_int_done;
  logic [31:0]       eip_reg;
  logic              in_valid = 1'b0, in_ready;
  logic [SEQW-1:0]   in_entry = '0;
  logic [CW:0]       in_len = '0;
  logic [UOPW-1:0]   in_payload = '0;
  logic [IADDRW-1:0] in_pc = '0;
  logic              out_valid, out_ready = 1'b1;
  logic [SEQW-1:0]   out_entry;
  logic [CW-1:0]     out_step;
  logic              out_first, out_last, out_int;
  logic [UOPW-1:0]   out_payload;
  logic [IADDRW-1:0] out_pc;

  decode_uop_seq dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .handle_int_i(handle_int),
    .handle_int_done_o(handle_int_done), .write_eip_i(write_eip), .eip_i(eip),
    .eip_reg_o(eip_reg), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_entry_i(in_entry), .in_len_i(in_len), .in_payload_i(in_payload), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_entry_o(out_entry),
    .out_step_o(out_step), .out_first_o(out_first), .out_last_o(out_last),
    .out_int_o(out_int), .out_payload_o(out_payload), .out_pc_o(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEQW-1:0]   entry;
    logic [CW-1:0]     step;
    logic              first;
    logic              last;
    logic              intr;
    logic [UOPW-1:0]   payload;
    logic [IADDRW-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, done_cnt = 0;
  bit   stall_prev = 0;
  exp_t stall_val;

  // A bundle of length L becomes max(1, min(L, MAXLEN)) beats numbered 0..n-1.
  function automatic void push_seq(int entry, int len, logic [UOPW-1:0] pl,
                                   logic [IADDRW-1:0] pc, bit intr);
    int n;
    n = (len == 0) ? 1 : ((len > MAXLEN) ? MAXLEN : len);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.entry = SEQW'(entry); e.step = CW'(i); e.first = (i == 0); e.last = (i == n-1);
      e.intr = intr; e.payload = pl; e.pc = pc;
      exp_q.push_back(e);
    end
  endfunction

  // One clock: called at a negedge after inputs are set; scores handshakes, returns at next negedge.
  task automatic tick();
    exp_t got, want;
    #1;
    got = {out_entry, out_step, out_first, out_last, out_int, out_payload, out_pc};
    if (stall_prev) begin
      n_cmp++;
      if (got !== stall_val) begin
        n_bad++; $display("FAIL stall_hold: got %h required %h", got, stall_val);
      end
    end
    if (out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL extra_beat: got %h required no beat", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++; $display("FAIL beat: got %h required %h", got, want);
        end
        n_cmp++;
        if (handle_int_done !== (want.last && want.intr)) begin
          n_bad++; $display("FAIL int_done: got %b required %b", handle_int_done, want.last && want.intr);
        end
      end
    end else begin
      n_cmp++;
      if (handle_int_done !== 1'b0) begin
        n_bad++; $display("FAIL int_done_idle: got %b required 0", handle_int_done);
      end
    end
    if (handle_int_done === 1'b1) done_cnt++;
    if (in_valid && in_ready) push_seq(in_entry, in_len, in_payload, in_pc, 1'b0);
    if (flush) exp_q.delete();
    stall_prev = out_valid && !out_ready && !flush;
    stall_val  = got;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    in_valid = 0; out_ready = 1; handle_int = 0; flush = 0; write_eip = 0;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 60) begin tick(); k++; end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain: got %0d pending/valid %b required 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic send(int entry, int len);
    in_valid = 1; in_entry = SEQW'(entry); in_len = (CW+1)'(len);
    in_payload = {$urandom, $urandom}; in_pc = $urandom;
  endtask

  task automatic load_eip(logic [31:0] v);
    in_valid = 0; eip = v; write_eip = 1;
    tick();
    write_eip = 0;
    n_cmp++;
    if (eip_reg !== v) begin n_bad++; $display("FAIL eip_reg: got %h required %h", eip_reg, v); end
  endtask

  task automatic wait_int_start();
    int k = 0;
    while (!(out_valid && out_int && out_step == 0) && k < 60) begin tick(); k++; end
    n_cmp++;
    if (k >= 60) begin n_bad++; $display("FAIL int_start_timeout: got none required int beat 0"); end
    handle_int = 0;
  endtask

  task automatic test_reset();
    in_valid = 1; out_ready = 1; write_eip = 1; eip = 32'hDEAD_BEEF;
    #12;
    n_cmp += 6;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (handle_int_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b required 0", handle_int_done); end
    if (eip_reg !== 32'h0) begin n_bad++; $display("FAIL rst_eip: got %h required 0", eip_reg); end
    if (out_payload !== '0 || out_pc !== '0) begin n_bad++; $display("FAIL rst_data: got %h/%h required 0", out_payload, out_pc); end
    if (out_step !== '0 || out_entry !== '0) begin n_bad++; $display("FAIL rst_step: got %0d/%0d required 0", out_step, out_entry); end
    @(negedge clk);
    reset = 0; in_valid = 0; write_eip = 0;
  endtask

  task automatic test_basic_seq();
    out_ready = 1;
    send(2, 3);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_idle: got %b required 1", in_ready); end
    tick();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp += 3;
      if (out_valid !== 1'b1 || out_step !== CW'(k)) begin
        n_bad++; $display("FAIL basic_step: got v%b s%0d required v1 s%0d", out_valid, out_step, k);
      end
      if (out_first !== (k == 0) || out_last !== (k == 2)) begin
        n_bad++; $display("FAIL basic_flags: got f%b l%b required f%b l%b", out_first, out_last, k == 0, k == 2);
      end
      if (in_ready !== (k == 2)) begin
        n_bad++; $display("FAIL basic_in_ready: got %b required %b at step %0d", in_ready, k == 2, k);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_end: got %b required 0", out_valid); end
    tick();
    drain();
  endtask

  task automatic test_len_bounds();
    send(1, 0);
    tick();
    in_valid = 0;
    n_cmp++;
    if (out_first !== 1'b1 || out_last !== 1'b1) begin
      n_bad++; $display("FAIL len0_flags: got f%b l%b required f1 l1", out_first, out_last);
    end
    drain();
    send(3, 7);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    n_cmp++;
    if (out_last !== 1'b1 || out_step !== CW'(3)) begin
      n_bad++; $display("FAIL len_clamp: got l%b s%0d required l1 s3", out_last, out_step);
    end
    drain();
  endtask

  task automatic test_int_deferred();
    logic [31:0] ev;
    int d0;
    d0 = done_cnt;
    ev = $urandom;
    load_eip(ev);
    send(5, 4);
    tick();
    in_valid = 0;
    tick();
    handle_int = 1;
    push_seq(INT_ENTRY, INT_LEN, '0, ev, 1'b1);
    wait_int_start();
    drain();
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL int_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    send(4, 4);
    tick();
    in_valid = 0;
    tick();
    out_ready = 0;
    tick(); tick(); tick();
    out_ready = 1;
    drain();
  endtask

  task automatic test_flush();
    send(1, 4);
    out_ready = 0;
    tick();
    send(2, 2);
    flush = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    #1;
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle: got %b required 1", in_ready); end
    tick();
    out_ready = 1;
    send(3, 2);
    tick();
    drain();
  endtask

  task automatic test_reset_mid_int();
    logic [31:0] ev;
    int d0;
    ev = $urandom | 32'h1;
    load_eip(ev);
    handle_int = 1;
    push_seq(INT_ENTRY, INT_LEN, '0, ev, 1'b1);
    wait_int_start();
    d0 = done_cnt;
    #2 reset = 1;
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
    if (eip_reg !== 32'h0) begin n_bad++; $display("FAIL rmid_eip: got %h required 0", eip_reg); end
    if (handle_int_done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b required 0", handle_int_done); end
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_in_ready: got %b required 0", in_ready); end
    exp_q.delete();
    stall_prev = 0;
    @(negedge clk);
    reset = 0;
    tick(); tick();
    n_cmp++;
    if (done_cnt != d0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_after: got done+%0d v%b required done+0 v0", done_cnt - d0, out_valid);
    end
    drain();
  endtask

  task automatic test_random();
    int phase = 0, waitk = 0;
    logic [31:0] ev;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      write_eip = 0;
      case (phase)
        0: begin
          if ($urandom_range(0, 29) == 0) begin
            ev = $urandom; eip = ev; write_eip = 1; in_valid = 0; phase = 1;
          end else begin
            send($urandom_range(0, 7), $urandom_range(0, 7));
            in_valid = ($urandom_range(0, 1) == 1);
          end
        end
        1: begin
          in_valid = 0; handle_int = 1;
          push_seq(INT_ENTRY, INT_LEN, '0, ev, 1'b1);
          phase = 2; waitk = 0;
        end
        default: begin
          in_valid = 0;
          if (out_valid && out_int && out_step == 0) begin
            handle_int = 0; phase = 0;
          end else if (++waitk > 60) begin
            n_cmp++; n_bad++;
            $display("FAIL rand_int_timeout: got none required int beat 0");
            handle_int = 0; phase = 0;
          end
        end
      endcase
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_seq();
    test_len_bounds();
    test_int_deferred();
    test_stall();
    test_flush();
    test_reset_mid_int();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end
endmodule
